// File: rtl/prio_code_decoder_if.sv
// Handshake bundle carrying a 2-bit priority code (y index + z valid flag)
// from the encoder side to the decoder.
interface prio_code_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_y;
  logic       in_z;

  modport master (
    output in_valid,
    output in_y,
    output in_z,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_y,
    input  in_z,
    output in_ready
  );
endinterface

// File: rtl/prio_code_decoder.sv
// Expands an accepted priority code into a one-hot line vector held for
// HOLD_CYCLES, then idles for GAP_CYCLES; counts empty (z=0) codes.
module prio_code_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  prio_code_decoder_if.slave in_if,
  output logic [3:0]       w_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          xfer;

  assign in_if.in_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign xfer           = in_if.in_valid & in_if.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      w_out   <= 4'b0000;
      done    <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (in_if.in_z) begin
              state <= DRIVE;
              cnt   <= HOLD_LD;
              w_out <= 4'b0001 << in_if.in_y;
            end else if (err_cnt != {CNT_W{1'b1}}) begin
              err_cnt <= err_cnt + CNT_W'(1);
            end
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            w_out <= 4'b0000;
            done  <= 1'b1;
            // GAP_CYCLES==0 returns straight to IDLE after the done cycle
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_LD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          w_out <= 4'b0000;
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= IDLE;
        end
        default: begin
          state <= IDLE;
          w_out <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Directed bench: table-driven run on the default configuration plus
// short hand sequences for saturation and HOLD=1/GAP=0 operation.
module tb_prio_code_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, rb, rc;

  prio_code_decoder_if a_if();
  prio_code_decoder_if b_if();
  prio_code_decoder_if c_if();

  logic [3:0] wa, wb, wc;
  logic       ba, bb, bc;
  logic       da, db, dc;
  logic [7:0] ea;
  logic [1:0] eb;
  logic [7:0] ec;

  prio_code_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(ra), .in_if(a_if.slave),
    .w_out(wa), .busy(ba), .done(da), .err_cnt(ea)
  );

  prio_code_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rb), .in_if(b_if.slave),
    .w_out(wb), .busy(bb), .done(db), .err_cnt(eb)
  );

  prio_code_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut_c (
    .clk(clk), .reset(rc), .in_if(c_if.slave),
    .w_out(wc), .busy(bc), .done(dc), .err_cnt(ec)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] y;
    logic       z;
    logic [3:0] w;
    logic       d;
    logic       r;
    logic       b;
    logic [7:0] e;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(logic rst, logic v, logic [1:0] y,
                              logic z, logic [3:0] w, logic d,
                              logic r, logic b, logic [7:0] e);
    vec_t t;
    t.rst = rst; t.v = v; t.y = y; t.z = z;
    t.w = w; t.d = d; t.r = r; t.b = b; t.e = e;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    logic [3:0] w1;
    logic [1:0] ys [4];
    ys[0] = 2'd3; ys[1] = 2'd2; ys[2] = 2'd1; ys[3] = 2'd0;

    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_y = 2'd0; a_if.in_z = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_y = 2'd0; b_if.in_z = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_y = 2'd0; c_if.in_z = 1'b0;

    // reset, then 5 idle cycles
    add(1, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);

    // single code y=2
    add(0, 1, 2, 1, 4'b0100, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 4'b0100, 0, 0, 1, 0);
    add(0, 0, 0, 0, 4'b0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);

    // back-to-back 3,2,1,0 with in_valid held high
    for (int k = 0; k < 4; k++) begin
      w1 = 4'b0001 << ys[k];
      add(0, 1, ys[k], 1, w1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++)
        add(0, 1, ys[k], 1, w1, 0, 0, 1, 0);
      add(0, 1, ys[k], 1, 4'b0000, 1, 0, 1, 0);
      add(0, 1, ys[k], 1, 4'b0000, 0, 1, 0, 0);
    end

    // three empty codes with in_y unknown
    add(0, 1, 2'bxx, 0, 4'b0000, 0, 1, 0, 1);
    add(0, 1, 2'bxx, 0, 4'b0000, 0, 1, 0, 2);
    add(0, 1, 2'bxx, 0, 4'b0000, 0, 1, 0, 3);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 0, 3);

    // reset during the second DRIVE cycle of y=1
    add(0, 1, 1, 1, 4'b0010, 0, 0, 1, 3);
    add(0, 0, 0, 0, 4'b0010, 0, 0, 1, 3);
    add(1, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      ra            = tbl[i].rst;
      a_if.in_valid = tbl[i].v;
      a_if.in_y     = tbl[i].y;
      a_if.in_z     = tbl[i].z;
      @(posedge clk);
      #1;
      chk($sformatf("a_w[%0d]", i),     32'(wa), 32'(tbl[i].w));
      chk($sformatf("a_done[%0d]", i),  32'(da), 32'(tbl[i].d));
      chk($sformatf("a_ready[%0d]", i), 32'(a_if.in_ready), 32'(tbl[i].r));
      chk($sformatf("a_busy[%0d]", i),  32'(ba), 32'(tbl[i].b));
      chk($sformatf("a_err[%0d]", i),   32'(ea), 32'(tbl[i].e));
      chk($sformatf("a_onehot[%0d]", i),
          32'($countones(wa) <= 1), 32'd1);
    end

    // saturation with a 2-bit error counter
    @(negedge clk);
    rb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_if.in_valid = 1'b1;
      b_if.in_z     = 1'b0;
      b_if.in_y     = 2'bxx;
      @(posedge clk);
      #1;
      chk($sformatf("b_err[%0d]", i), 32'(eb), (i < 3) ? i + 1 : 3);
      chk($sformatf("b_w[%0d]", i),   32'(wb), 32'd0);
      chk($sformatf("b_done[%0d]", i), 32'(db), 32'd0);
    end
    @(negedge clk);
    b_if.in_valid = 1'b0;

    // HOLD=1, GAP=0: alternating 0001 / 0000 with done on the zero cycles
    rc            = 1'b0;
    c_if.in_valid = 1'b1;
    c_if.in_y     = 2'd0;
    c_if.in_z     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("c_w[%0d]", i),
          32'(wc), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("c_done[%0d]", i),
          32'(dc), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("c_ready[%0d]", i),
          32'(c_if.in_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    c_if.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
